// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LU    = 2'd1,
    MWAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXE    = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Per-operand forward select: EXE ALU result beats MEM result; r0 never forwarded.
module fwd_sel
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] i_src,
  input  logic          i_exe_wreg,
  input  logic          i_exe_m2reg,
  input  logic [RW-1:0] i_exe_rn,
  input  logic          i_mem_wreg,
  input  logic          i_mem_m2reg,
  input  logic [RW-1:0] i_mem_rn,
  output logic [1:0]    o_sel
);

  logic w_exe_hit, w_mem_hit;

  // A load in EXE has no data yet; that case is the load-use stall, not a forward.
  assign w_exe_hit = i_exe_wreg & ~i_exe_m2reg & (i_exe_rn != '0) & (i_exe_rn == i_src);
  assign w_mem_hit = i_mem_wreg & (i_mem_rn != '0) & (i_mem_rn == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_exe_hit)      o_sel = FWD_EXE;
    else if (w_mem_hit) o_sel = i_mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding selects, load-use stall and slow-memory hold for the 5-stage pipeline.
// Optional HAZ_PERF_EN adds saturating stall/hold/forward counters.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int RW   = 5,
  parameter int CNTW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          exe_wreg,
  input  logic          exe_m2reg,
  input  logic [RW-1:0] exe_rn,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic          mem_wmem,
  input  logic [RW-1:0] mem_rn,
  input  logic          mem_ready,
  output logic [1:0]    fwda,
  output logic [1:0]    fwdb,
  output logic          wpcir,
  output logic          bubble,
  output logic          hold,
  output logic          hz_err
`ifdef HAZ_PERF_EN
  ,
  output logic [CNTW-1:0] lu_stall_cnt,
  output logic [CNTW-1:0] mwait_cnt,
  output logic [CNTW-1:0] fwd_cnt
`endif
);

  if (RW < 1 || CNTW < 1) begin : g_bad_param
    $error("hazard_fwd_ctrl: RW and CNTW must be positive");
  end

  hz_state_e r_state, w_nstate;
  logic      r_hz_err, w_err_set;
  logic [1:0] w_fwda, w_fwdb;
  logic      w_load_use, w_mem_busy;
  logic      w_wpcir, w_bubble, w_hold;

  fwd_sel #(.RW(RW)) u_fwd_a (
    .i_src(id_rs), .i_exe_wreg(exe_wreg), .i_exe_m2reg(exe_m2reg), .i_exe_rn(exe_rn),
    .i_mem_wreg(mem_wreg), .i_mem_m2reg(mem_m2reg), .i_mem_rn(mem_rn), .o_sel(w_fwda)
  );

  fwd_sel #(.RW(RW)) u_fwd_b (
    .i_src(id_rt), .i_exe_wreg(exe_wreg), .i_exe_m2reg(exe_m2reg), .i_exe_rn(exe_rn),
    .i_mem_wreg(mem_wreg), .i_mem_m2reg(mem_m2reg), .i_mem_rn(mem_rn), .o_sel(w_fwdb)
  );

  assign w_load_use = exe_wreg & exe_m2reg & (exe_rn != '0) &
                      ((id_use_rs & (exe_rn == id_rs)) | (id_use_rt & (exe_rn == id_rt)));
  assign w_mem_busy = (mem_m2reg | mem_wmem) & ~mem_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= RUN;
      r_hz_err <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_hz_err <= r_hz_err | w_err_set;
    end
  end

  // RUN and MWAIT evaluate identically: a ready memory releases the hold in the
  // same cycle and falls straight into normal load-use evaluation.
  always_comb begin
    w_nstate  = RUN;
    w_wpcir   = 1'b1;
    w_bubble  = 1'b0;
    w_hold    = 1'b0;
    w_err_set = 1'b0;
    if (w_mem_busy) begin
      w_hold   = 1'b1;
      w_wpcir  = 1'b0;
      w_nstate = MWAIT;
    end else if (w_load_use) begin
      w_wpcir   = 1'b0;
      w_bubble  = 1'b1;
      w_nstate  = LU;
      // The load should have moved to MEM by now; a repeat means bad sequencing.
      w_err_set = (r_state == LU);
    end
  end

  assign fwda   = clr ? FWD_RF : w_fwda;
  assign fwdb   = clr ? FWD_RF : w_fwdb;
  assign wpcir  = ~clr & w_wpcir;
  assign bubble = ~clr & w_bubble;
  assign hold   = ~clr & w_hold;
  assign hz_err = r_hz_err;

`ifdef HAZ_PERF_EN
  logic [CNTW-1:0] r_lu_cnt, r_mw_cnt, r_fw_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_lu_cnt <= '0;
      r_mw_cnt <= '0;
      r_fw_cnt <= '0;
    end else begin
      if (bubble && r_lu_cnt != '1) r_lu_cnt <= r_lu_cnt + 1'b1;
      if (hold && r_mw_cnt != '1)   r_mw_cnt <= r_mw_cnt + 1'b1;
      if ((fwda != FWD_RF || fwdb != FWD_RF) && r_fw_cnt != '1) r_fw_cnt <= r_fw_cnt + 1'b1;
    end
  end

  assign lu_stall_cnt = r_lu_cnt;
  assign mwait_cnt    = r_mw_cnt;
  assign fwd_cnt      = r_fw_cnt;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Random + directed bench for hazard_fwd_ctrl against a cycle-level behavioural model.
module tb_hazard_fwd_ctrl;

  localparam int RW = 5;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0, clr = 1'b1;
  logic [RW-1:0] id_rs, id_rt, exe_rn, mem_rn;
  logic id_use_rs, id_use_rt, exe_wreg, exe_m2reg, mem_wreg, mem_m2reg, mem_wmem, mem_ready;
  logic [1:0] fwda, fwdb;
  logic wpcir, bubble, hold, hz_err;
`ifdef HAZ_PERF_EN
  logic [CNTW-1:0] lu_stall_cnt, mwait_cnt, fwd_cnt;
`endif

  hazard_fwd_ctrl #(.RW(RW), .CNTW(CNTW)) dut (
    .clk(clk), .clr(clr), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem), .mem_rn(mem_rn),
    .mem_ready(mem_ready), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
    .bubble(bubble), .hold(hold), .hz_err(hz_err)
`ifdef HAZ_PERF_EN
    , .lu_stall_cnt(lu_stall_cnt), .mwait_cnt(mwait_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: "was a bubble issued last cycle" is all the history the rules need.
  bit m_prev_bub = 0, m_err = 0;
  int m_lu = 0, m_mw = 0, m_fw = 0;
  logic [1:0] e_fa, e_fb;
  bit e_wpc, e_bub, e_hold;

  function automatic logic [1:0] mfwd(input logic [RW-1:0] src);
    if (exe_wreg && !exe_m2reg && exe_rn != 0 && exe_rn == src) return 2'd1;
    if (mem_wreg && mem_rn != 0 && mem_rn == src) return mem_m2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic step();
    bit lu, busy, nerr;
    int fwa, fwb;
    #1;
    lu   = exe_wreg && exe_m2reg && exe_rn != 0 &&
           ((id_use_rs && exe_rn == id_rs) || (id_use_rt && exe_rn == id_rt));
    busy = (mem_m2reg || mem_wmem) && !mem_ready;
    fwa  = int'(mfwd(id_rs));
    fwb  = int'(mfwd(id_rt));
    if (clr) begin
      e_fa = 0; e_fb = 0; e_wpc = 0; e_bub = 0; e_hold = 0;
    end else begin
      e_fa = 2'(fwa); e_fb = 2'(fwb);
      e_hold = busy;
      e_bub  = !busy && lu;
      e_wpc  = !busy && !lu;
    end
    chk("fwda", 32'(fwda), 32'(e_fa));
    chk("fwdb", 32'(fwdb), 32'(e_fb));
    chk("wpcir", 32'(wpcir), 32'(e_wpc));
    chk("bubble", 32'(bubble), 32'(e_bub));
    chk("hold", 32'(hold), 32'(e_hold));
    nerr = m_err || (m_prev_bub && e_bub);
    @(posedge clk);
    #1;
    if (clr) begin
      m_prev_bub = 0; m_err = 0; m_lu = 0; m_mw = 0; m_fw = 0;
    end else begin
      m_prev_bub = e_bub;
      m_err = nerr;
      if (e_bub && m_lu < CMAX) m_lu++;
      if (e_hold && m_mw < CMAX) m_mw++;
      if ((e_fa != 0 || e_fb != 0) && m_fw < CMAX) m_fw++;
    end
    chk("hz_err", 32'(hz_err), 32'(m_err));
`ifdef HAZ_PERF_EN
    chk("lu_cnt", 32'(lu_stall_cnt), 32'(m_lu));
    chk("mw_cnt", 32'(mwait_cnt), 32'(m_mw));
    chk("fw_cnt", 32'(fwd_cnt), 32'(m_fw));
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    exe_wreg = 0; exe_m2reg = 0; exe_rn = 0;
    mem_wreg = 0; mem_m2reg = 0; mem_wmem = 0; mem_rn = 0; mem_ready = 1;
  endtask

  task automatic set_load_use();
    idle();
    exe_wreg = 1; exe_m2reg = 1; exe_rn = 5; id_use_rt = 1; id_rt = 5;
  endtask

  initial begin
    idle();
    @(negedge clk);
    step();
    chk("rst_wpcir", 32'(wpcir), 32'd0);
    chk("rst_err", 32'(hz_err), 32'd0);
    clr = 0;

    // EXE beats MEM; r0 never forwarded
    idle();
    id_rs = 3; exe_wreg = 1; exe_rn = 3; mem_wreg = 1; mem_rn = 3;
    #1 chk("fwda_pri", 32'(fwda), 32'd1);
    chk("fwdb_r0", 32'(fwdb), 32'd0);
    step();

    // load-use, then load reaches MEM
    set_load_use();
    #1 chk("lu_bub", 32'(bubble), 32'd1);
    step();
    idle();
    mem_wreg = 1; mem_m2reg = 1; mem_rn = 5; id_use_rt = 1; id_rt = 5;
    #1 chk("lu_fwdb", 32'(fwdb), 32'd3);
    chk("lu_wpc", 32'(wpcir), 32'd1);
    step();

    // slow memory: 3 wait cycles then release
    idle();
    mem_m2reg = 1; mem_ready = 0;
    repeat (3) step();
    mem_ready = 1;
    #1 chk("mw_rel", 32'(hold), 32'd0);
    step();

    // simultaneous busy + load-use
    set_load_use();
    mem_wmem = 1; mem_ready = 0;
    #1 chk("sim_bub", 32'(bubble), 32'd0);
    step();
    mem_ready = 1;
    #1 chk("sim_rel", 32'(bubble), 32'd1);
    step();
    idle();
    step();

    // load-use persisting in LU raises the sticky error
    set_load_use();
    step(); step();
    chk("err_set", 32'(hz_err), 32'd1);
    idle();
    step();
    chk("err_stk", 32'(hz_err), 32'd1);
    mem_m2reg = 1; mem_ready = 0;
    step();
    clr = 1;
    step();
    clr = 0;
    chk("clr_err", 32'(hz_err), 32'd0);
    #1 chk("clr_hold", 32'(hold), 32'd1);
    idle();
    step();

`ifdef HAZ_PERF_EN
    // 20 consecutive stalls drives the 4-bit counter into saturation
    repeat (20) begin
      set_load_use();
      step();
      idle();
      step();
    end
    chk("lu_sat", 32'(lu_stall_cnt), 32'(CMAX));
`endif

    // random soak
    for (int i = 0; i < 600; i++) begin
      id_rs = RW'($urandom_range(0, 3)); id_rt = RW'($urandom_range(0, 3));
      exe_rn = RW'($urandom_range(0, 3)); mem_rn = RW'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      exe_wreg = 1'($urandom); exe_m2reg = 1'($urandom);
      mem_wreg = 1'($urandom); mem_m2reg = 1'($urandom); mem_wmem = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 59) == 0);
      step();
    end
    clr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
